mmio_uart_responder: RTL and testbench

- Memory-mapped IO responder on the CPU side of the IO address window.
- Answers the datapath's X-stage loads and stores: byte-lane store mask, word address, store data, and returned load data.
- Buffers bytes between the CPU and a UART byte-stream transmitter/receiver in two small FIFOs.
- Provides a free-running cycle counter.
- The CPU never stalls, so every access completes in one cycle; overflow conditions are flagged, never back-pressured.

---
 rtl/mmio_pkg.sv | 29 ++
 rtl/mmio_uart_responder_if.sv | 19 +
 rtl/mmio_uart_responder_sync_fifo.sv | 55 +++++
 rtl/mmio_uart_responder.sv | 164 ++++++++++++++++
 tb/tb_mmio_uart_responder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO UART responder: register offsets, status bit
// positions and the IO window base used by the memory map.
package mmio_pkg;

    localparam logic [31:0] IO_BASE = 32'h8000_0000;

    // Register offsets, decoded from io_addr[4:2]
    localparam logic [2:0] RX_CTRL = 3'd0;
    localparam logic [2:0] RX_DATA = 3'd1;
    localparam logic [2:0] TX_CTRL = 3'd2;
    localparam logic [2:0] TX_DATA = 3'd3;
    localparam logic [2:0] CYCLE   = 3'd4;

    // Status bit positions inside RX_CTRL / TX_CTRL
    localparam int RX_NONEMPTY_BIT = 0;
    localparam int RX_OVF_BIT      = 1;
    localparam int TX_NOTFULL_BIT  = 0;
    localparam int TX_OVF_BIT      = 1;

    // Both control registers share the {ovf, ready} layout.
    function automatic logic [31:0] statusWord(input logic ovf, input logic ready);
        logic [31:0] word;
        word = '0;
        word[RX_OVF_BIT] = ovf;
        word[RX_NONEMPTY_BIT] = ready;
        return word;
    endfunction

endpackage

// File: rtl/mmio_uart_responder_if.sv
// X-stage IO bus between the datapath (master) and the MMIO responder (slave).
interface mmio_uart_responder_if;
    logic        io_sel;
    logic [31:0] io_addr;
    logic [3:0]  io_we;
    logic [31:0] io_wdata;
    logic        io_re;
    logic [31:0] io_rdata;

    modport master (
        output io_sel, io_addr, io_we, io_wdata, io_re,
        input  io_rdata
    );

    modport slave (
        input  io_sel, io_addr, io_we, io_wdata, io_re,
        output io_rdata
    );
endinterface

// File: rtl/mmio_uart_responder_sync_fifo.sv
// Small synchronous FIFO with a combinational head; a push into a full FIFO
// lands when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtrReg;
    logic [AW:0]      rdPtrReg;
    logic             doPush;
    logic             doPop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty  = (wrPtrReg == rdPtrReg);
    assign full   = (wrPtrReg[AW] != rdPtrReg[AW]) &&
                    (wrPtrReg[AW-1:0] == rdPtrReg[AW-1:0]);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PTR_ONE;
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrReg[AW-1:0]] <= pushData;
        end
    end

    // Head is forced to zero while empty so stale storage never leaks out.
    assign head = empty ? '0 : mem[rdPtrReg[AW-1:0]];

endmodule

// File: rtl/mmio_uart_responder.sv
// MMIO responder bridging single-cycle CPU loads/stores to UART byte FIFOs,
// plus a free-running cycle counter. Define MMIO_LOOPBACK_EN to route TX into RX.
module mmio_uart_responder
    import mmio_pkg::*;
#(
    parameter int RX_DEPTH  = 8,
    parameter int TX_DEPTH  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mmio_uart_responder_if.slave         bus,
    input  logic                         rx_in_valid,
    input  logic [7:0]                   rx_in_data,
    output logic                         rx_in_ready,
    output logic                         tx_out_valid,
    output logic [7:0]                   tx_out_data,
    input  logic                         tx_out_ready
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [2:0]           offset;
    logic                 regWrite;
    logic                 regRead;

    logic                 rxPush;
    logic [7:0]           rxPushData;
    logic                 rxPop;
    logic [7:0]           rxHead;
    logic                 rxFull;
    logic                 rxEmpty;
    logic                 rxOvfSet;

    logic                 txPush;
    logic                 txPop;
    logic [7:0]           txHead;
    logic                 txFull;
    logic                 txEmpty;
    logic                 txOvfSet;

    logic                 rxOvfReg;
    logic                 rxOvfNext;
    logic                 txOvfReg;
    logic                 txOvfNext;
    logic [CNT_WIDTH-1:0] cycleCntReg;
    logic [CNT_WIDTH-1:0] cycleCntNext;

    logic                 unusedBits;

    assign offset   = bus.io_addr[4:2];
    assign regWrite = bus.io_sel && (|bus.io_we);
    assign regRead  = bus.io_sel && bus.io_re;

    assign rxPop  = regRead && (offset == RX_DATA);
    assign txPush = bus.io_sel && (offset == TX_DATA) && bus.io_we[0];

    assign rx_in_ready = 1'b1;
    assign tx_out_data = txHead;

`ifdef MMIO_LOOPBACK_EN
    logic loopMove;
    logic unusedUart;

    // At most one byte per cycle, and only when RX has room, so RX never overflows.
    assign loopMove     = !txEmpty && !rxFull;
    assign rxPush       = loopMove;
    assign rxPushData   = txHead;
    assign txPop        = loopMove;
    assign tx_out_valid = 1'b0;
    assign rxOvfSet     = 1'b0;
    assign unusedUart   = ^{rx_in_valid, rx_in_data, tx_out_ready};
`else
    assign rxPush       = rx_in_valid;
    assign rxPushData   = rx_in_data;
    assign txPop        = tx_out_ready;
    assign tx_out_valid = !txEmpty;
    // A pop in the same cycle makes room, so the byte is not lost.
    assign rxOvfSet     = rx_in_valid && rxFull && !rxPop;
`endif

    assign txOvfSet = txPush && txFull && !txPop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) rxFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rxPush),
        .pushData (rxPushData),
        .pop      (rxPop),
        .head     (rxHead),
        .full     (rxFull),
        .empty    (rxEmpty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) txFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (txPush),
        .pushData (bus.io_wdata[7:0]),
        .pop      (txPop),
        .head     (txHead),
        .full     (txFull),
        .empty    (txEmpty)
    );

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
        rxOvfNext = rxOvfReg;
        txOvfNext = txOvfReg;
        if (regWrite && (offset == RX_CTRL)) begin
            rxOvfNext = 1'b0;
        end
        if (rxOvfSet) begin
            rxOvfNext = 1'b1;
        end
        if (regWrite && (offset == TX_CTRL)) begin
            txOvfNext = 1'b0;
        end
        if (txOvfSet) begin
            txOvfNext = 1'b1;
        end
    end

    always_comb begin
        cycleCntNext = cycleCntReg + CNT_ONE;
        if (regWrite && (offset == CYCLE)) begin
            cycleCntNext = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxOvfReg    <= 1'b0;
            txOvfReg    <= 1'b0;
            cycleCntReg <= '0;
        end else begin
            rxOvfReg    <= rxOvfNext;
            txOvfReg    <= txOvfNext;
            cycleCntReg <= cycleCntNext;
        end
    end

    always_comb begin
        bus.io_rdata = '0;
        if (regRead) begin
            case (offset)
                RX_CTRL: bus.io_rdata = statusWord(rxOvfReg, !rxEmpty);
                RX_DATA: bus.io_rdata = {24'b0, rxHead};
                TX_CTRL: bus.io_rdata = statusWord(txOvfReg, !txFull);
                CYCLE:   bus.io_rdata = 32'(cycleCntReg);
                default: bus.io_rdata = '0;
            endcase
        end
    end

    // Address bits above the window and below word alignment are not decoded.
    assign unusedBits = ^{bus.io_addr[31:5], bus.io_addr[1:0], bus.io_wdata[31:8]};

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Directed bench for mmio_uart_responder; with MMIO_LOOPBACK_EN defined it runs
// the loopback scenario instead of the external UART paths.
module tb_mmio_uart_responder;
    import mmio_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       rx_in_valid;
    logic [7:0] rx_in_data;
    logic       rx_in_ready;
    logic       tx_out_valid;
    logic [7:0] tx_out_data;
    logic       tx_out_ready;

    int compareCount;
    int mismatchCount;

    mmio_uart_responder_if bus ();

    mmio_uart_responder #(
        .RX_DEPTH  (8),
        .TX_DEPTH  (8),
        .CNT_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .rx_in_valid  (rx_in_valid),
        .rx_in_data   (rx_in_data),
        .rx_in_ready  (rx_in_ready),
        .tx_out_valid (tx_out_valid),
        .tx_out_data  (tx_out_data),
        .tx_out_ready (tx_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Every bus task starts on a falling edge and returns on the next one.
    task automatic busIdle();
        bus.io_sel   = 1'b0;
        bus.io_addr  = '0;
        bus.io_we    = '0;
        bus.io_wdata = '0;
        bus.io_re    = 1'b0;
        @(negedge clk);
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
        bus.io_sel   = 1'b1;
        bus.io_addr  = addr;
        bus.io_we    = we;
        bus.io_wdata = data;
        bus.io_re    = 1'b0;
        @(negedge clk);
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
        bus.io_sel   = 1'b1;
        bus.io_addr  = addr;
        bus.io_we    = '0;
        bus.io_wdata = '0;
        bus.io_re    = 1'b1;
        #2;
        data = bus.io_rdata;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        found;

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst_n        = 1'b0;
        rx_in_valid  = 1'b0;
        rx_in_data   = '0;
        tx_out_ready = 1'b0;
        bus.io_sel   = 1'b0;
        bus.io_addr  = '0;
        bus.io_we    = '0;
        bus.io_wdata = '0;
        bus.io_re    = 1'b0;

        repeat (2) @(negedge clk);
        checkEq("rst_tx_valid", 32'(tx_out_valid), 32'h0);
        checkEq("rst_tx_data", 32'(tx_out_data), 32'h0);
        rst_n = 1'b1;
        busRead(32'h10, rd);  checkEq("init_cycle0", rd, 32'h0);
        busRead(32'h10, rd);  checkEq("init_cycle1", rd, 32'h1);
        busRead(32'h08, rd);  checkEq("init_tx_ctrl", rd, 32'h1);
        busRead(32'h00, rd);  checkEq("init_rx_ctrl", rd, 32'h0);
        checkEq("rx_in_ready", 32'(rx_in_ready), 32'h1);
        busRead(32'h14, rd);  checkEq("unmapped_read", rd, 32'h0);

`ifdef MMIO_LOOPBACK_EN
        busWrite(32'h8000_000C, 4'b0001, 32'h0000_0033);
        found = 1'b0;
        for (int i = 0; i < 3 && !found; i++) begin
            checkEq("lb_tx_valid", 32'(tx_out_valid), 32'h0);
            busRead(32'h00, rd);
            if (rd[0]) found = 1'b1;
        end
        checkEq("lb_arrived", 32'(found), 32'h1);
        busRead(32'h04, rd);  checkEq("lb_rx_data", rd, 32'h33);
        checkEq("lb_tx_valid_end", 32'(tx_out_valid), 32'h0);
        busRead(32'h00, rd);  checkEq("lb_rx_ctrl_end", rd, 32'h0);
`else
        // Reset mid-traffic: 3 TX bytes queued, counter at 0x50
        for (int i = 1; i <= 3; i++) busWrite(32'h0C, 4'b0001, 32'(i));
        checkEq("mid_tx_valid", 32'(tx_out_valid), 32'h1);
        checkEq("mid_tx_head", 32'(tx_out_data), 32'h01);
        busWrite(32'h10, 4'b1111, 32'h0);
        repeat (8'h50) busIdle();
        busRead(32'h10, rd);  checkEq("mid_cycle", rd, 32'h50);
        rst_n = 1'b0;
        #1;
        checkEq("mid_rst_tx_valid", 32'(tx_out_valid), 32'h0);
        checkEq("mid_rst_tx_data", 32'(tx_out_data), 32'h0);
        busIdle();
        rst_n = 1'b1;
        busRead(32'h10, rd);  checkEq("post_cycle0", rd, 32'h0);
        busRead(32'h10, rd);  checkEq("post_cycle1", rd, 32'h1);
        busRead(32'h08, rd);  checkEq("post_tx_ctrl", rd, 32'h1);
        checkEq("post_tx_valid", 32'(tx_out_valid), 32'h0);

        // TX path: SB then SW; upper lanes of the SB must not matter
        busWrite(32'h8000_000F, 4'b0001, 32'h4141_4141);
        busWrite(32'h0000_000C, 4'b1111, 32'h0000_0042);
        busRead(32'h0C, rd);  checkEq("tx_data_read", rd, 32'h0);
        checkEq("tx_valid_a", 32'(tx_out_valid), 32'h1);
        checkEq("tx_head_a", 32'(tx_out_data), 32'h41);
        tx_out_ready = 1'b1;
        busIdle();
        checkEq("tx_valid_b", 32'(tx_out_valid), 32'h1);
        checkEq("tx_head_b", 32'(tx_out_data), 32'h42);
        busIdle();
        checkEq("tx_valid_end", 32'(tx_out_valid), 32'h0);
        tx_out_ready = 1'b0;

        // TX overflow: 9 pushes into 8 entries
        for (int i = 0; i < 9; i++) busWrite(32'h0C, 4'b0001, 32'h10 + 32'(i));
        busRead(32'h08, rd);  checkEq("tx_ovf_ctrl", rd, 32'h2);
        busWrite(32'h08, 4'b0100, 32'h0);
        busRead(32'h08, rd);  checkEq("tx_ovf_cleared", rd, 32'h0);
        tx_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkEq("tx_ovf_drain", 32'(tx_out_data), 32'h10 + 32'(i));
            busIdle();
        end
        checkEq("tx_ovf_empty", 32'(tx_out_valid), 32'h0);
        tx_out_ready = 1'b0;

        // Push at full with a simultaneous pop
        for (int i = 0; i < 8; i++) busWrite(32'h0C, 4'b0001, 32'h20 + 32'(i));
        tx_out_ready = 1'b1;
        busWrite(32'h0C, 4'b0001, 32'h28);
        checkEq("tx_full_pop_head", 32'(tx_out_data), 32'h21);
        busIdle();
        tx_out_ready = 1'b0;
        busRead(32'h08, rd);  checkEq("tx_full_pop_ctrl", rd, 32'h1);
        tx_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            checkEq("tx_full_pop_drain", 32'(tx_out_data), 32'h22 + 32'(i));
            busIdle();
        end
        checkEq("tx_full_pop_empty", 32'(tx_out_valid), 32'h0);
        tx_out_ready = 1'b0;

        // RX path
        rx_in_valid = 1'b1;
        rx_in_data  = 8'hA5;  busIdle();
        rx_in_data  = 8'h5A;  busIdle();
        rx_in_valid = 1'b0;
        bus.io_sel  = 1'b0;
        bus.io_addr = 32'h04;
        bus.io_re   = 1'b1;
        #2;
        checkEq("rx_unselected_read", bus.io_rdata, 32'h0);
        @(negedge clk);
        busRead(32'h00, rd);  checkEq("rx_ctrl_a", rd, 32'h1);
        busRead(32'h04, rd);  checkEq("rx_data_a5", rd, 32'hA5);
        busRead(32'h04, rd);  checkEq("rx_data_5a", rd, 32'h5A);
        busRead(32'h04, rd);  checkEq("rx_data_empty", rd, 32'h0);
        busRead(32'h00, rd);  checkEq("rx_ctrl_empty", rd, 32'h0);

        // RX overflow: 9 bytes, no pops
        rx_in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_in_data = 8'h60 + 8'(i);
            busIdle();
        end
        rx_in_valid = 1'b0;
        busRead(32'h00, rd);  checkEq("rx_ovf_ctrl", rd, 32'h3);
        for (int i = 0; i < 8; i++) begin
            busRead(32'h04, rd);
            checkEq("rx_ovf_drain", rd, 32'h60 + 32'(i));
        end
        busRead(32'h00, rd);  checkEq("rx_ovf_sticky", rd, 32'h2);
        busWrite(32'h00, 4'b1000, 32'h0);
        busRead(32'h00, rd);  checkEq("rx_ovf_cleared", rd, 32'h0);

        // Push at full with a simultaneous CPU pop: push lands, no overflow
        rx_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_in_data = 8'h70 + 8'(i);
            busIdle();
        end
        rx_in_data = 8'h78;
        busRead(32'h04, rd);  checkEq("rx_full_pop_data", rd, 32'h70);
        rx_in_valid = 1'b0;
        busRead(32'h00, rd);  checkEq("rx_full_pop_ctrl", rd, 32'h1);
        for (int i = 0; i < 8; i++) begin
            busRead(32'h04, rd);
            checkEq("rx_full_pop_drain", rd, 32'h71 + 32'(i));
        end

        // Counter clear from a single non-zero lane beats increment
        busWrite(32'h10, 4'b0010, 32'h0);
        busRead(32'h10, rd);  checkEq("cycle_clr0", rd, 32'h0);
        busRead(32'h10, rd);  checkEq("cycle_clr1", rd, 32'h1);
`endif

        busIdle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
